// File: rtl/sub_pkg.sv
// sub_pkg: shared constants and the S1 stage record
// for the pipelined subtractor.
package sub_pkg;

  localparam int SUB_DEFAULT_WIDTH = 22;
  localparam int SUB_DEPTH = 3;
  localparam int SUB_MAX_WIDTH = 128;
  localparam int SUB_MAX_LO = SUB_MAX_WIDTH / 2;
  localparam int SUB_MAX_HI = SUB_MAX_WIDTH - SUB_MAX_LO;

  // Sized for the widest legal operand; narrower
  // builds use the low bits of each field.
  typedef struct packed {
    logic                  valid;
    logic                  borrow;
    logic [SUB_MAX_LO-1:0] lo;
    logic [SUB_MAX_HI-1:0] a_hi;
    logic [SUB_MAX_HI-1:0] b_hi;
  } s1_rec_t;

endpackage

// File: rtl/sub_half_stage.sv
// sub_half_stage: combinational WIDTH-bit subtract
// with borrow in/out.
// Ports: a, b (operands), bin (borrow in),
//        d (difference), bout (borrow out).
module sub_half_stage #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic [WIDTH:0] full;

  // The extra top bit goes to 1 exactly when
  // a - b - bin is negative, i.e. a borrow out.
  assign full = {1'b0, a}
              - {1'b0, b}
              - {{WIDTH{1'b0}}, bin};

  assign d    = full[WIDTH-1:0];
  assign bout = full[WIDTH];

endmodule

// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor: 3-stage valid/ready a - b,
// split into low and high halves across S1 and S2.
// Ports: clk, reset (sync, active high),
//   in_valid/in_ready/a/b (operand input),
//   out_valid/out_ready/diff/underflow (result).
// Build option: SUB_SATURATE_EN clamps negative
//   results to diff = 0 with underflow = 1.
module pipelined_subtractor
  import sub_pkg::*;
#(
  parameter int ADDER_WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDER_WIDTH:0] diff,
  output logic                 underflow
);

  localparam int W  = ADDER_WIDTH;
  localparam int LO = W / 2;
  localparam int HI = W - LO;

  if (W < 2 || W > SUB_MAX_WIDTH) begin : g_bad_w
    $error("ADDER_WIDTH out of range");
  end

  logic         s0_v;
  logic [W-1:0] s0_a;
  logic [W-1:0] s0_b;

  s1_rec_t s1_q;
  s1_rec_t s1_d;
  logic    s1_unused;

  logic s2_v;

  logic s0_rdy;
  logic s1_rdy;
  logic s2_rdy;

  // Ready ripples back from the consumer so a
  // full pipe can still move every cycle.
  assign s2_rdy = !s2_v || out_ready;
  assign s1_rdy = !s1_q.valid || s2_rdy;
  assign s0_rdy = !s0_v || s1_rdy;

  assign in_ready  = s0_rdy && !reset;
  assign out_valid = s2_v;

  // S0: operand capture
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_v <= 1'b0;
      s0_a <= '0;
      s0_b <= '0;
    end else if (s0_rdy) begin
      s0_v <= in_valid;
      if (in_valid) begin
        s0_a <= a;
        s0_b <= b;
      end
    end
  end

  // S1: low half
  logic [LO-1:0] lo_d;
  logic          lo_bout;

  sub_half_stage #(
    .WIDTH(LO)
  ) u_lo (
    .a    (s0_a[LO-1:0]),
    .b    (s0_b[LO-1:0]),
    .bin  (1'b0),
    .d    (lo_d),
    .bout (lo_bout)
  );

  always_comb begin
    s1_d = '0;
    s1_d.valid  = s0_v;
    s1_d.borrow = lo_bout;
    s1_d.lo[LO-1:0]   = lo_d;
    s1_d.a_hi[HI-1:0] = s0_a[W-1:LO];
    s1_d.b_hi[HI-1:0] = s0_b[W-1:LO];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
    end else if (s1_rdy) begin
      if (s0_v) begin
        s1_q <= s1_d;
      end else begin
        s1_q.valid <= 1'b0;
      end
    end
  end

  // Record fields are max-width; the spare
  // upper bits are intentionally left idle.
  assign s1_unused = ^s1_q;

  // S2: high half with the S1 borrow
  logic [HI-1:0] hi_d;
  logic          hi_bout;
  logic [W:0]    raw;
  logic [W:0]    res_d;
  logic          res_uf;

  sub_half_stage #(
    .WIDTH(HI)
  ) u_hi (
    .a    (s1_q.a_hi[HI-1:0]),
    .b    (s1_q.b_hi[HI-1:0]),
    .bin  (s1_q.borrow),
    .d    (hi_d),
    .bout (hi_bout)
  );

  // Final borrow is the sign of the
  // (W+1)-bit two's-complement result.
  assign raw    = {hi_bout, hi_d, s1_q.lo[LO-1:0]};
  assign res_uf = raw[W];

`ifdef SUB_SATURATE_EN
  assign res_d = res_uf ? '0 : raw;
`else
  assign res_d = raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v      <= 1'b0;
      diff      <= '0;
      underflow <= 1'b0;
    end else if (s2_rdy) begin
      s2_v <= s1_q.valid;
      if (s1_q.valid) begin
        diff      <= res_d;
        underflow <= res_uf;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// tb_pipelined_subtractor: self-checking bench with
// directed boundary cases and a randomized scoreboard.
module tb_pipelined_subtractor;
  import sub_pkg::*;

  localparam int W = 22;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   diff;
  logic         underflow;

  int checks = 0;
  int errors = 0;

  pipelined_subtractor #(
    .ADDER_WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference: {underflow, diff} from plain arithmetic
  function automatic logic [W+1:0] ref_sub(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    ref_sub = {d[W], d};
`ifdef SUB_SATURATE_EN
    if (d[W]) ref_sub = {1'b1, {(W+1){1'b0}}};
`endif
  endfunction

  function automatic logic [W-1:0] pick();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return W'($urandom);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0",
               in_ready);
    end
    checks++;
    if ({out_valid, underflow, diff} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b u=%b d=%h want 0",
               out_valid, underflow, diff);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b want 1",
               in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8];
    logic [W-1:0] tb_ [8];
    logic [W:0]   td [8];
    logic         tu [8];
    ta  = '{22'd5, 22'h000800, 22'h0, 22'h3FFFFF,
            22'h2AAAAA, 22'h0, 22'h001000, 22'h3FFFFF};
    tb_ = '{22'd3, 22'h1, 22'h1, 22'h0,
            22'h2AAAAA, 22'h3FFFFF, 22'h000FFF, 22'h3FFFFF};
    td  = '{23'h2, 23'h0007FF, 23'h7FFFFF, 23'h3FFFFF,
            23'h0, 23'h400001, 23'h1, 23'h0};
    tu  = '{1'b0, 1'b0, 1'b1, 1'b0,
            1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int cyc;
      logic [W:0] exp_d;
      exp_d = td[i];
`ifdef SUB_SATURATE_EN
      if (tu[i]) exp_d = '0;
`endif
      @(negedge clk);
      in_valid = 1'b1;
      a = ta[i];
      b = tb_[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_ready[%0d]: got %b want 1",
                 i, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != SUB_DEPTH) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d want %0d",
                 i, cyc, SUB_DEPTH);
      end
      checks++;
      if (diff !== exp_d || underflow !== tu[i]) begin
        errors++;
        $display("FAIL dir_result[%0d]: got d=%h u=%b want d=%h u=%b",
                 i, diff, underflow, exp_d, tu[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa [5];
    logic [W-1:0] xb [5];
    logic [W+1:0] ex [5];
    logic [W+1:0] held;
    logic have;
    int sent;
    int got;
    for (int i = 0; i < 5; i++) begin
      xa[i] = W'($urandom);
      xb[i] = W'($urandom);
      ex[i] = ref_sub(xa[i], xb[i]);
    end
    sent = 0;
    got = 0;
    have = 1'b0;
    held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (sent < 5);
      if (sent < 5) begin
        a = xa[sent];
        b = xb[sent];
      end
      #1;
      if (out_valid) begin
        if (!have) begin
          held = {underflow, diff};
          have = 1'b1;
        end else begin
          checks++;
          if ({underflow, diff} !== held) begin
            errors++;
            $display("FAIL stall_hold: got %h want %h",
                     {underflow, diff}, held);
          end
        end
      end
      if (in_valid && in_ready) sent++;
    end
    checks++;
    if (sent != 3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_backpressure: got sent=%0d rdy=%b want 3 0",
               sent, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid: got %b want 1", out_valid);
    end
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (out_valid && out_ready) begin
        checks++;
        if ({underflow, diff} !== ex[got]) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got %h want %h",
                   got, {underflow, diff}, ex[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      in_valid = (sent < 5);
      if (sent < 5) begin
        a = xa[sent];
        b = xb[sent];
      end
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5 || sent != 5) begin
      errors++;
      $display("FAIL b2b_count: got out=%0d in=%0d want 5 5",
               got, sent);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic [W+1:0] e;
    int n;
    int lat;
    for (int i = 0; i < 3; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
    end
    e = ref_sub(pa[2], pb[2]);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    a = pa[0];
    b = pb[0];
    @(negedge clk);
    a = pa[1];
    b = pb[1];
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flush: got %b want 0", out_valid);
    end
    in_valid = 1'b1;
    a = pa[2];
    b = pb[2];
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_accept: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (out_valid) begin
        n++;
        if (n == 1) begin
          lat = c;
          checks++;
          if ({underflow, diff} !== e) begin
            errors++;
            $display("FAIL mid_reset_result: got %h want %h",
                     {underflow, diff}, e);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 1 || lat != SUB_DEPTH) begin
      errors++;
      $display("FAIL mid_reset_count: got n=%0d lat=%0d want 1 %0d",
               n, lat, SUB_DEPTH);
    end
  endtask

  task automatic test_random();
    logic [W+1:0] q [$];
    logic [W+1:0] e;
    logic [W+2:0] held;
    logic stall;
    stall = 1'b0;
    held = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (stall) begin
        checks++;
        if ({out_valid, underflow, diff} !== held) begin
          errors++;
          $display("FAIL rnd_hold: got %h want %h",
                   {out_valid, underflow, diff}, held);
        end
      end
      if (q.size() == 3 && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL rnd_full_ready: got %b want 0",
                   in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious: got %h want none",
                   {underflow, diff});
        end else begin
          e = q.pop_front();
          if ({underflow, diff} !== e) begin
            errors++;
            $display("FAIL rnd_result: got %h want %h",
                     {underflow, diff}, e);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(ref_sub(a, b));
      stall = out_valid && !out_ready;
      held  = {out_valid, underflow, diff};
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_drain_extra: got %h want none",
                   {underflow, diff});
        end else begin
          e = q.pop_front();
          if ({underflow, diff} !== e) begin
            errors++;
            $display("FAIL rnd_drain: got %h want %h",
                     {underflow, diff}, e);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_lost: got %0d left want 0", q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
